// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer in front of a word-addressed, combinational-read SRAM.
// Selects byte lanes, extends loads, and read-modify-writes sub-word stores.
module lsu_mem_ctrl #(
  parameter int unsigned addr_width = 16,
  parameter int unsigned data_width = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [addr_width+1:0]   req_addr,
  input  logic [data_width-1:0]   req_wdata,
  output logic                    resp_valid,
  output logic [data_width-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [addr_width-1:0]   mem_addr,
  output logic [data_width-1:0]   mem_wr_data,
  input  logic [data_width-1:0]   mem_rd_data
);

  localparam int unsigned byte_addr_width = addr_width + 2;
  localparam logic [1:0]  size_byte       = 2'b00;
  localparam logic [1:0]  size_half       = 2'b01;
  localparam logic [1:0]  size_word       = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t                       state;
  logic [byte_addr_width-1:0]   addr_q;
  logic                         we_q;
  logic [1:0]                   size_q;
  logic                         signed_q;
  logic [data_width-1:0]        wdata_q;
  logic                         req_err_c;

  // Illegal size or a lane offset that is not a multiple of the access size.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] lane);
    return (size == 2'b11) ||
           (size == size_half && lane[0]) ||
           (size == size_word && lane != 2'b00);
  endfunction

  function automatic logic [data_width-1:0] load_ext(input logic [data_width-1:0] word,
                                                     input logic [1:0] size,
                                                     input logic [1:0] lane,
                                                     input logic       sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      size_byte: return {{24{sgn & b[7]}}, b};
      size_half: return {{16{sgn & h[15]}}, h};
      default:   return word;
    endcase
  endfunction

  // Replace only the addressed lane(s); every other byte of the old word survives.
  function automatic logic [data_width-1:0] store_merge(input logic [data_width-1:0] word,
                                                        input logic [data_width-1:0] wdata,
                                                        input logic [1:0] size,
                                                        input logic [1:0] lane);
    logic [data_width-1:0] r;
    r = word;
    case (size)
      size_byte: r[{lane, 3'b000} +: 8]     = wdata[7:0];
      size_half: r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default:   r = wdata;
    endcase
    return r;
  endfunction

  assign req_err_c = access_err(req_size, req_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      wdata_q     <= '0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else begin
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            we_q      <= req_we;
            size_q    <= req_size;
            signed_q  <= req_signed;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (req_err_c) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_we && req_size == size_word) begin
              state       <= WR;
              mem_en      <= 1'b1;
              mem_we      <= 1'b1;
              mem_addr    <= req_addr[byte_addr_width-1:2];
              mem_wr_data <= req_wdata;
            end else begin
              state    <= RD;
              mem_en   <= 1'b1;
              mem_addr <= req_addr[byte_addr_width-1:2];
            end
          end
        end
        // Old word is consumed straight off the SRAM read port at this edge.
        RD: begin
          if (we_q) begin
            state       <= WR;
            mem_en      <= 1'b1;
            mem_we      <= 1'b1;
            mem_addr    <= addr_q[byte_addr_width-1:2];
            mem_wr_data <= store_merge(mem_rd_data, wdata_q, size_q, addr_q[1:0]);
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_ext(mem_rd_data, size_q, addr_q[1:0], signed_q);
          end
        end
        WR: begin
          state      <= RESP;
          resp_valid <= 1'b1;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized self-checking bench for lsu_mem_ctrl against a byte-arithmetic memory model.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [17:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wr_data, mem_rd_data;

  logic        bd_we;
  logic [15:0] bd_addr;
  logic [31:0] bd_data;
  logic [31:0] sram [0:65535];
  int unsigned ref_mem [0:65535];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  // SRAM: combinational read, posedge write, with a bench backdoor write port.
  assign mem_rd_data = sram[mem_addr];
  always @(posedge clk) begin
    if (bd_we) sram[bd_addr] <= bd_data;
    else if (mem_en && mem_we) sram[mem_addr] <= mem_wr_data;
  end

  function automatic bit ref_is_err(input logic [1:0] size, input logic [17:0] addr);
    int unsigned a;
    a = 32'(addr);
    return (size == 2'd3) || (size == 2'd1 && (a % 2) != 0) || (size == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic int unsigned ref_load(input logic [1:0] size, input logic sgn, input logic [17:0] addr);
    int unsigned a, w, v;
    a = 32'(addr);
    w = ref_mem[a / 4];
    if (size == 2'd0) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (sgn && v >= 128) v = v + 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (sgn && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [17:0] addr, input logic [31:0] wdata);
    int unsigned a, sh, mask;
    a = 32'(addr);
    if (size == 2'd0) begin
      sh = 8 * (a % 4);
      mask = 32'hFF << sh;
      ref_mem[a / 4] = (ref_mem[a / 4] & ~mask) | ((wdata & 32'hFF) << sh);
    end else if (size == 2'd1) begin
      sh = 16 * ((a / 2) % 2);
      mask = 32'hFFFF << sh;
      ref_mem[a / 4] = (ref_mem[a / 4] & ~mask) | ((wdata & 32'hFFFF) << sh);
    end else begin
      ref_mem[a / 4] = wdata;
    end
  endtask

  task automatic bd_write(input logic [15:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // Issues one request and observes it until its response (entered and left #1 after an edge).
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [17:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int we_cyc, output int en_cyc, output int addr_bad);
    int guard;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; rdata = '0; err = 1'b0; we_cyc = 0; en_cyc = 0; addr_bad = 0;
    for (int k = 1; k <= 8; k++) begin
      if (mem_en) begin
        en_cyc++;
        if (mem_addr !== addr[17:2]) addr_bad++;
      end
      if (mem_we) we_cyc++;
      if (resp_valid) begin
        lat = k; rdata = resp_rdata; err = resp_err;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid: got %b exp 0", resp_valid); end
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_en_we: got %b%b exp 00", mem_en, mem_we); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready: got %b exp 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL post_rst_resp_valid: got %b exp 0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL rst_resp_err: got %b exp 0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL rst_resp_rdata: got %h exp 0", resp_rdata); end
    checks++; if (mem_addr !== 16'h0 || mem_wr_data !== 32'h0) begin failures++; $display("FAIL rst_mem_bus: got %h/%h exp 0/0", mem_addr, mem_wr_data); end
  endtask

  task automatic test_load_ext();
    int lat, wc, ec, ab; logic [31:0] rd; logic er;
    bd_write(16'h0010, 32'h8899AABB);
    do_req(1'b0, 2'd0, 1'b1, 18'h00043, 32'h0, lat, rd, er, wc, ec, ab);
    checks++; if (lat != 2) begin failures++; $display("FAIL lb_signed_lat: got %0d exp 2", lat); end
    checks++; if (rd !== 32'hFFFFFF88) begin failures++; $display("FAIL lb_signed_data: got %h exp ffffff88", rd); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL lb_signed_err: got %b exp 0", er); end
    do_req(1'b0, 2'd0, 1'b0, 18'h00043, 32'h0, lat, rd, er, wc, ec, ab);
    checks++; if (rd !== 32'h00000088) begin failures++; $display("FAIL lb_unsigned_data: got %h exp 00000088", rd); end
  endtask

  task automatic test_word_store();
    int lat, wc, ec, ab; logic [31:0] rd; logic er;
    do_req(1'b1, 2'd2, 1'b0, 18'h00100, 32'hDEADBEEF, lat, rd, er, wc, ec, ab);
    checks++; if (lat != 2) begin failures++; $display("FAIL sw_lat: got %0d exp 2", lat); end
    checks++; if (wc != 1) begin failures++; $display("FAIL sw_we_cycles: got %0d exp 1", wc); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL sw_rdata: got %h exp 0", rd); end
    do_req(1'b0, 2'd2, 1'b0, 18'h00100, 32'h0, lat, rd, er, wc, ec, ab);
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_after_sw: got %h exp deadbeef", rd); end
  endtask

  task automatic test_subword_store();
    int lat, wc, ec, ab; logic [31:0] rd; logic er;
    bd_write(16'h0040, 32'h11223344);
    do_req(1'b1, 2'd0, 1'b0, 18'h00102, 32'h000000A5, lat, rd, er, wc, ec, ab);
    checks++; if (lat != 3) begin failures++; $display("FAIL sb_lat: got %0d exp 3", lat); end
    checks++; if (sram[16'h0040] !== 32'h11A53344) begin failures++; $display("FAIL sb_word: got %h exp 11a53344", sram[16'h0040]); end
    do_req(1'b1, 2'd1, 1'b0, 18'h00100, 32'h0000BEEF, lat, rd, er, wc, ec, ab);
    checks++; if (lat != 3) begin failures++; $display("FAIL sh_lat: got %0d exp 3", lat); end
    checks++; if (sram[16'h0040] !== 32'h11A5BEEF) begin failures++; $display("FAIL sh_word: got %h exp 11a5beef", sram[16'h0040]); end
  endtask

  task automatic test_errors();
    int lat, wc, ec, ab; logic [31:0] rd; logic er;
    logic [1:0]  sz [3];
    logic [17:0] ad [3];
    sz[0] = 2'd1; ad[0] = 18'h00001;
    sz[1] = 2'd2; ad[1] = 18'h00002;
    sz[2] = 2'd3; ad[2] = 18'h00000;
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, sz[i], 1'b0, ad[i], 32'h0, lat, rd, er, wc, ec, ab);
      checks++; if (lat != 1) begin failures++; $display("FAIL err%0d_lat: got %0d exp 1", i, lat); end
      checks++; if (er !== 1'b1) begin failures++; $display("FAIL err%0d_flag: got %b exp 1", i, er); end
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL err%0d_rdata: got %h exp 0", i, rd); end
      checks++; if (ec != 0) begin failures++; $display("FAIL err%0d_mem_en: got %0d cycles exp 0", i, ec); end
    end
  endtask

  task automatic test_random();
    int lat, wc, ec, ab, e_lat, e_en, e_we;
    logic [31:0] rd, wd, e_rd; logic er, we, sg, e_er;
    logic [1:0] sz; logic [17:0] ad;
    for (int w = 0; w < 8; w++) bd_write(16'h0200 + 16'(w), $urandom);
    for (int n = 0; n < 150; n++) begin
      we = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      sg = 1'($urandom_range(0, 1));
      ad = 18'h00800 + 18'($urandom_range(0, 31));
      wd = $urandom;
      e_er = ref_is_err(sz, ad);
      if (e_er) begin
        e_rd = '0; e_lat = 1; e_en = 0; e_we = 0;
      end else if (!we) begin
        e_rd = ref_load(sz, sg, ad); e_lat = 2; e_en = 1; e_we = 0;
      end else begin
        e_rd = '0; e_lat = (sz == 2'd2) ? 2 : 3; e_en = (sz == 2'd2) ? 1 : 2; e_we = 1;
        ref_store(sz, ad, wd);
      end
      do_req(we, sz, sg, ad, wd, lat, rd, er, wc, ec, ab);
      checks++; if (lat != e_lat) begin failures++; $display("FAIL rnd%0d_lat: got %0d exp %0d", n, lat, e_lat); end
      checks++; if (rd !== e_rd) begin failures++; $display("FAIL rnd%0d_rdata: got %h exp %h", n, rd, e_rd); end
      checks++; if (er !== e_er) begin failures++; $display("FAIL rnd%0d_err: got %b exp %b", n, er, e_er); end
      checks++; if (ec != e_en) begin failures++; $display("FAIL rnd%0d_en_cycles: got %0d exp %0d", n, ec, e_en); end
      checks++; if (wc != e_we) begin failures++; $display("FAIL rnd%0d_we_cycles: got %0d exp %0d", n, wc, e_we); end
      checks++; if (ab != 0) begin failures++; $display("FAIL rnd%0d_mem_addr: got %0d bad cycles exp 0", n, ab); end
    end
    for (int w = 0; w < 8; w++) begin
      checks++;
      if (sram[16'h0200 + 16'(w)] !== ref_mem[16'h0200 + 16'(w)]) begin
        failures++;
        $display("FAIL rnd_mem_word%0d: got %h exp %h", w, sram[16'h0200 + 16'(w)], ref_mem[16'h0200 + 16'(w)]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q_rd [$];
    logic        q_er [$];
    logic [31:0] x_rd; logic x_er;
    int acc, rsp, cyc; bit pend;
    acc = 0; rsp = 0; cyc = 0;
    req_we = 1'b0; req_wdata = '0;
    req_size = 2'($urandom_range(0, 3)); req_signed = 1'($urandom_range(0, 1));
    req_addr = 18'h00800 + 18'($urandom_range(0, 31));
    req_valid = 1'b1;
    while ((acc < 20 || q_rd.size() > 0) && cyc < 400) begin
      pend = req_valid && req_ready;
      @(posedge clk); #1;
      cyc++;
      if (pend) begin
        x_er = ref_is_err(req_size, req_addr);
        q_er.push_back(x_er);
        q_rd.push_back(x_er ? 32'h0 : ref_load(req_size, req_signed, req_addr));
        acc++;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_after_accept: got %b exp 0", req_ready); end
        if (acc == 20) req_valid = 1'b0;
        else begin
          req_size = 2'($urandom_range(0, 3)); req_signed = 1'($urandom_range(0, 1));
          req_addr = 18'h00800 + 18'($urandom_range(0, 31));
        end
      end
      if (resp_valid) begin
        rsp++;
        checks++;
        if (q_rd.size() == 0) begin
          failures++; $display("FAIL b2b_spurious_resp: got resp with %0d outstanding exp 0 responses", q_rd.size());
        end else begin
          x_rd = q_rd.pop_front(); x_er = q_er.pop_front();
          if (resp_rdata !== x_rd || resp_err !== x_er) begin
            failures++; $display("FAIL b2b_resp%0d: got %h/%b exp %h/%b", rsp, resp_rdata, resp_err, x_rd, x_er);
          end
        end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_in_resp: got %b exp 0", req_ready); end
      end
    end
    req_valid = 1'b0;
    checks++; if (acc != 20 || rsp != 20) begin failures++; $display("FAIL b2b_counts: got acc=%0d rsp=%0d exp 20/20", acc, rsp); end
  endtask

  task automatic test_reset_in_wr();
    int guard;
    guard = 0;
    while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    bd_write(16'h0300, 32'hCAFEF00D);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 18'h00C01; req_wdata = 32'h00000055;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL rwr_we_in_wr: got %b exp 1", mem_we); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rwr_we_drop: got %b exp 0", mem_we); end
    @(posedge clk); #1;
    checks++; if (sram[16'h0300] !== 32'hCAFEF00D) begin failures++; $display("FAIL rwr_word_kept: got %h exp cafef00d", sram[16'h0300]); end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rwr_ready: got %b exp 1", req_ready); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rwr_no_resp%0d: got %b exp 0", i, resp_valid); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_ext();
    test_word_store();
    test_subword_store();
    test_errors();
    test_random();
    test_back_to_back();
    test_reset_in_wr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store sequencer directly upstream of the word-addressed data SRAM (combinational read, posedge write, whole-word writes only).
- Takes byte-addressed load/store requests from the execute stage and handles byte lane selection and sign/zero extension.
- Performs a read-modify-write for sub-word stores and reports misaligned or illegal accesses.
- One request in flight; valid/ready request side, single-cycle response pulse.

Parameters:
addr_width, 16, SRAM word-address width; the CPU byte address is addr_width+2 bits.
data_width, 32, word width; fixed at 32 (4 byte lanes).

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
req_signed  in  1  loads: 1 = sign-extend, 0 = zero-extend
req_addr  in  addr_width+2  byte address
req_wdata  in  data_width  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  data_width  extended load data; 0 for stores and errors
resp_err  out  1  qualified by resp_valid: misaligned or illegal size
mem_en  out  1  to SRAM en
mem_we  out  1  to SRAM we
mem_addr  out  addr_width  to SRAM addr = latched req_addr[addr_width+1:2]
mem_wr_data  out  data_width  to SRAM wr_data
mem_rd_data  in  data_width  from SRAM data, combinational

Behaviour:
- Handshake: a request is accepted on a posedge when req_valid && req_ready. At acceptance, latch addr, we, size, signed and wdata.
- req_ready = 1 only in IDLE.
- resp_valid is a single-cycle pulse with no back-pressure.
- State machine: IDLE, RD, WR, RESP.
  - IDLE: accepted and error -> RESP (err=1). Accepted load or sub-word store -> RD. Accepted word store -> WR.
  - RD: mem_en=1. At the edge, sample mem_rd_data into old_word. Load -> RESP; sub-word store -> WR.
  - WR: mem_en=1, mem_we=1, mem_wr_data = merged word; SRAM commits at the edge -> RESP.
  - RESP: resp_valid=1 -> IDLE.
- Error: size 11, half with addr[0]=1, or word with addr[1:0]!=0. No SRAM access occurs (mem_en, mem_we stay 0). resp_err=1, resp_rdata=0.
- Latency from the accept edge to resp_valid high:
  - load and word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- Throughput: the next request is accepted in the cycle after RESP.
- Byte lanes are little-endian: byte lane = addr[1:0], half lane = addr[1].
  - Load byte: old_word[8*a+7:8*a], extended to 32 bits.
  - Load half: old_word[16*h+15:16*h], extended to 32 bits.
  - Load word: old_word unchanged.
- Store merge: old_word with the selected lane(s) replaced by req_wdata low bits; all other bytes preserved exactly.
- mem_en, mem_we, mem_addr and mem_wr_data are decoded from registered state and latches only, with no combinational path from req_*.
  - mem_addr = 0 and mem_wr_data = 0 in IDLE and RESP.
- Reset (asynchronous, rst_n=0):
  - state=IDLE, all latches 0.
  - req_ready=1 once released; resp_valid=0, resp_err=0, resp_rdata=0, mem_en=0, mem_we=0.
  - Reset asserted during WR drops mem_we immediately, so no SRAM write at the next edge. A partial RMW is abandoned with no response.
- Address wrap: the top byte address maps to the last SRAM word; there is no overflow handling.

Test Plan:
- Preload word 0x0010 = 0x8899AABB; load byte signed addr 0x0043 -> resp 2 cycles after accept, rdata 0xFFFFFF88, err=0. Same access unsigned -> 0x00000088.
- Word store 0xDEADBEEF to addr 0x0100 -> mem_we high exactly 1 cycle, resp at +2. Then word load of 0x0100 -> 0xDEADBEEF.
- Word 0x0040 = 0x11223344; byte store 0xA5 to addr 0x0102 -> word becomes 0x11A53344, resp at +3. Half store 0xBEEF to addr 0x0100 -> 0x11A5BEEF.
- Half load addr 0x0001, word load addr 0x0002, and size 11 -> each gives resp_err=1 at +1, rdata=0, mem_en never high.
- Hold req_valid high for back-to-back loads -> req_ready low outside IDLE, exactly one accept per response, no lost or duplicated request.
- Assert rst_n=0 mid-cycle during the WR state of a sub-word store -> mem_we drops immediately and the SRAM word is unchanged. After release: req_ready=1, resp_valid=0.
